// File: rtl/data_mem_unit_if.sv
// rtl/data_mem_unit_if.sv - datapath <-> data-memory bus bundle
interface data_mem_unit_if;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [7:0]  ReadData;
    logic        stall;

    modport master (
        output MemWrite,
        output MemRead,
        output Address,
        output WriteData,
        input  ReadData,
        input  stall
    );

    modport slave (
        input  MemWrite,
        input  MemRead,
        input  Address,
        input  WriteData,
        output ReadData,
        output stall
    );
endinterface

// File: rtl/data_mem_unit.sv
// rtl/data_mem_unit.sv - byte RAM + I/O page data-memory stage; DMU_IO_SYNC_EN adds ioIn synchronizer
module data_mem_unit #(
    parameter int          ADDR_W  = 10,
    parameter logic [31:0] IO_BASE = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_unit_if.slave   bus,
    input  logic [7:0]       ioIn,
    output logic [7:0]       ioOut,
    output logic             errAddr
);

    localparam logic [31:0] RAM_BYTES  = 32'd1 << ADDR_W;
    localparam logic [31:0] IO_IN_ADDR = IO_BASE + 32'd4;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_DONE = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [7:0]         ram [RAM_BYTES];
    logic [7:0]         rdata_q;
    logic [7:0]         io_in_val;
    logic [ADDR_W-1:0]  ram_idx;
    logic               is_ram;
    logic               is_io_out;
    logic               is_io_in;
    logic               is_mapped;
    logic               ram_re;
    logic               ram_we;
    logic               io_we;
    logic               err_set;
    logic               stall_c;
    logic [7:0]         read_data_c;
    logic               unused_wdata;

    // Only the low byte of the store word is ever kept.
    assign unused_wdata = ^bus.WriteData[31:8];

    assign ram_idx   = bus.Address[ADDR_W-1:0];
    assign is_ram    = (bus.Address < RAM_BYTES);
    assign is_io_out = (bus.Address == IO_BASE);
    assign is_io_in  = (bus.Address == IO_IN_ADDR);
    assign is_mapped = is_ram | is_io_out | is_io_in;

`ifdef DMU_IO_SYNC_EN
    logic [7:0] io_sync1;
    logic [7:0] io_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            io_sync1 <= 8'h00;
            io_sync2 <= 8'h00;
        end else begin
            io_sync1 <= ioIn;
            io_sync2 <= io_sync1;
        end
    end

    assign io_in_val = io_sync2;
`else
    assign io_in_val = ioIn;
`endif

    // A simultaneous read+write keeps the write and drops the read, but is still flagged.
    assign err_set = ((bus.MemRead | bus.MemWrite) & ~is_mapped) |
                     (bus.MemRead & bus.MemWrite);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        stall_c     = 1'b0;
        ram_re      = 1'b0;
        ram_we      = 1'b0;
        io_we       = 1'b0;
        read_data_c = 8'h00;
        case (state)
            IDLE: begin
                if (bus.MemWrite) begin
                    ram_we = is_ram;
                    io_we  = is_io_out;
                end else if (bus.MemRead) begin
                    if (is_ram) begin
                        stall_c    = 1'b1;
                        ram_re     = 1'b1;
                        state_next = RD_DONE;
                    end else if (is_io_out) begin
                        read_data_c = ioOut;
                    end else if (is_io_in) begin
                        read_data_c = io_in_val;
                    end
                end
            end
            // The held load instruction is consumed here; its MemRead must not retrigger.
            RD_DONE: begin
                read_data_c = rdata_q;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.stall    = stall_c;
    assign bus.ReadData = read_data_c;

    // RAM contents survive reset; only the write strobe is suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && ram_we) begin
            ram[ram_idx] <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= 8'h00;
        end else if (ram_re) begin
            rdata_q <= ram[ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ioOut <= 8'h00;
        end else if (io_we) begin
            ioOut <= bus.WriteData[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            errAddr <= 1'b0;
        end else if (err_set) begin
            errAddr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_data_mem_unit.sv
// tb/tb_data_mem_unit.sv - scoreboard bench for data_mem_unit
module tb_data_mem_unit;

    localparam logic [31:0] IO_BASE = 32'h0000_1000;

    typedef struct {
        string      name;
        logic [7:0] rd;
        logic       st;
        logic [7:0] io;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [7:0] ioIn;
    logic [7:0] ioOut;
    logic       errAddr;

    int compared;
    int mismatched;
    exp_t sb[$];

    data_mem_unit_if bus ();

    data_mem_unit #(
        .ADDR_W  (10),
        .IO_BASE (IO_BASE)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .ioIn    (ioIn),
        .ioOut   (ioOut),
        .errAddr (errAddr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: one expectation per cycle, checked at the falling edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            compared++;
            if (bus.ReadData !== e.rd) begin
                mismatched++;
                $display("FAIL %s ReadData got %h want %h", e.name, bus.ReadData, e.rd);
            end
            compared++;
            if (bus.stall !== e.st) begin
                mismatched++;
                $display("FAIL %s stall got %b want %b", e.name, bus.stall, e.st);
            end
            compared++;
            if (ioOut !== e.io) begin
                mismatched++;
                $display("FAIL %s ioOut got %h want %h", e.name, ioOut, e.io);
            end
            compared++;
            if (errAddr !== e.err) begin
                mismatched++;
                $display("FAIL %s errAddr got %b want %b", e.name, errAddr, e.err);
            end
        end
    end

    task automatic cyc(input logic r, input logic mw, input logic mr,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [7:0] io,
                       input logic [7:0] erd, input logic est, input logic [7:0] eio,
                       input logic eerr, input string name);
        exp_t e;
        rst           = r;
        bus.MemWrite  = mw;
        bus.MemRead   = mr;
        bus.Address   = addr;
        bus.WriteData = wd;
        ioIn          = io;
        e.name = name; e.rd = erd; e.st = est; e.io = eio; e.err = eerr;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    localparam logic [7:0] IOV_EARLY =
`ifdef DMU_IO_SYNC_EN
        8'h00;
`else
        8'h81;
`endif

    initial begin
        compared   = 0;
        mismatched = 0;
        rst = 1'b1;
        bus.MemWrite = 1'b0; bus.MemRead = 1'b0;
        bus.Address = 32'h0; bus.WriteData = 32'h0;
        ioIn = 8'h00;
        @(posedge clk);
        #1;
        //   rst  mw   mr   addr           wdata          ioIn   rd     st   ioOut  err
        cyc(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "reset");
        cyc(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "idle");
        cyc(1'b0, 1'b1, 1'b0, 32'd5,         32'hDEAD_BEA5, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "st5");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "ld5_stall");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'hA5, 1'b0, 8'h00, 1'b0, "ld5_done");
        cyc(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "idle2");
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b0, 1'b1, 32'd5,     32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "b2b_stall");
            cyc(1'b0, 1'b0, 1'b1, 32'd5,     32'h0,         8'h00, 8'hA5, 1'b0, 8'h00, 1'b0, "b2b_done");
        end
        cyc(1'b0, 1'b1, 1'b0, IO_BASE,       32'h0000_003C, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "st_ioout");
        cyc(1'b0, 1'b0, 1'b1, IO_BASE,       32'h0,         8'h00, 8'h3C, 1'b0, 8'h3C, 1'b0, "ld_ioout");
        cyc(1'b0, 1'b0, 1'b1, IO_BASE+32'd4, 32'h0,         8'h81, IOV_EARLY, 1'b0, 8'h3C, 1'b0, "ld_ioin0");
        cyc(1'b0, 1'b0, 1'b1, IO_BASE+32'd4, 32'h0,         8'h81, IOV_EARLY, 1'b0, 8'h3C, 1'b0, "ld_ioin1");
        cyc(1'b0, 1'b0, 1'b1, IO_BASE+32'd4, 32'h0,         8'h81, 8'h81, 1'b0, 8'h3C, 1'b0, "ld_ioin2");
        cyc(1'b0, 1'b1, 1'b0, IO_BASE+32'd4, 32'h0000_00FF, 8'h81, 8'h00, 1'b0, 8'h3C, 1'b0, "st_ioin");
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h0,         8'h00, 8'h00, 1'b0, 8'h3C, 1'b0, "ld_unmapped");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'h00, 1'b1, 8'h3C, 1'b1, "err_sticky_a");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'hA5, 1'b0, 8'h3C, 1'b1, "err_sticky_b");
        cyc(1'b1, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h3C, 1'b1, "rst_err");
        cyc(1'b0, 1'b1, 1'b1, 32'd7,         32'h0000_0011, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "rw_both");
        cyc(1'b0, 1'b0, 1'b1, 32'd7,         32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "ld7_stall");
        cyc(1'b0, 1'b0, 1'b1, 32'd7,         32'h0,         8'h00, 8'h11, 1'b0, 8'h00, 1'b1, "ld7_done");
        cyc(1'b1, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "rst_in_stall");
        cyc(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "after_rst");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "ld5r_stall");
        cyc(1'b0, 1'b0, 1'b1, 32'd5,         32'h0,         8'h00, 8'hA5, 1'b0, 8'h00, 1'b0, "ld5r_done");
        cyc(1'b0, 1'b1, 1'b0, 32'd0,         32'h0000_0012, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "st0");
        cyc(1'b0, 1'b1, 1'b0, 32'h0000_0400, 32'h0000_0077, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "st_noalias");
        cyc(1'b0, 1'b0, 1'b1, 32'd0,         32'h0,         8'h00, 8'h00, 1'b1, 8'h00, 1'b1, "ld0_stall");
        cyc(1'b0, 1'b0, 1'b1, 32'd0,         32'h0,         8'h00, 8'h12, 1'b0, 8'h00, 1'b1, "ld0_noalias");
        cyc(1'b0, 1'b0, 1'b0, 32'h0,         32'h0,         8'h00, 8'h00, 1'b0, 8'h00, 1'b1, "final_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain pending %0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
